// File: rtl/proc_pkg.sv
// Shared control-flow types and instruction encodings for the fetch/branch pair.
// Pure declarations: no logic, no latency, no flow control.
package proc_pkg;

  localparam int PC_W    = 10;
  localparam int INSTR_W = 9;

  localparam logic [3:0]         OP_BRF     = 4'b1110;
  localparam logic [3:0]         OP_JMP     = 4'b1111;
  localparam logic [INSTR_W-1:0] INSTR_HALT = 9'h1FF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2,
    DONE     = 2'd3
  } prog_state_t;

endpackage

// File: rtl/target_lut.sv
// Jump-target register file: one sync write port, one async read port, cleared on reset.
// Read is combinational and sees the pre-write value of a same-cycle write; no backpressure.
module target_lut #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3,
  parameter int DAT_W = 10
) (
  input  logic             CLK,
  input  logic             Init_n,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [DAT_W-1:0] wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [DAT_W-1:0] rdata
);

  logic [DAT_W-1:0] mem [DEPTH];

  always_ff @(posedge CLK or negedge Init_n) begin
    if (!Init_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/branch_ctrl.sv
// Branch controller: decodes the current instruction, keeps the compare flag, issues registered redirects.
// Redirect appears one cycle after the taken op and squashes the in-flight instruction; no backpressure.
module branch_ctrl #(
  parameter int PC_W      = 10,
  parameter int INSTR_W   = 9,
  parameter int LUT_DEPTH = 8,
  parameter int LUT_IDX_W = 3,
  parameter int DATA_W    = 8
) (
  input  logic                 CLK,
  input  logic                 Init_n,
  input  logic                 Start,
  input  logic [INSTR_W-1:0]   Instr,
  input  logic                 Instr_valid,
  input  logic                 Cmp_en,
  input  logic [DATA_W-1:0]    Cmp_a,
  input  logic [DATA_W-1:0]    Cmp_b,
  input  logic                 Halt_in,
  input  logic                 Lut_we,
  input  logic [LUT_IDX_W-1:0] Lut_waddr,
  input  logic [PC_W-1:0]      Lut_wdata,
  output logic                 Branch_en,
  output logic                 FLAG_OUT,
  output logic [PC_W-1:0]      Target,
  output logic [1:0]           ProgState,
  output logic                 Squash,
  output logic                 Done,
  output logic [15:0]          Branch_cnt
);

  import proc_pkg::*;

  prog_state_t     state_q, state_d;
  logic            flag_q;
  logic [15:0]     cnt_q;
  logic [PC_W-1:0] target_q, lut_rdata;
  logic [3:0]      opcode;
  logic            dec_ok, is_halt, is_jmp, is_brf, take, redirect;

  target_lut #(.DEPTH(LUT_DEPTH), .IDX_W(LUT_IDX_W), .DAT_W(PC_W)) u_lut (
    .CLK    (CLK),
    .Init_n (Init_n),
    .we     (Lut_we),
    .waddr  (Lut_waddr),
    .wdata  (Lut_wdata),
    .raddr  (Instr[LUT_IDX_W-1:0]),
    .rdata  (lut_rdata)
  );

  // Decode is only meaningful in RUN; during REDIRECT the instruction is the squashed one.
  assign opcode   = Instr[INSTR_W-1 -: 4];
  assign dec_ok   = Instr_valid && (state_q == RUN);
  assign is_halt  = dec_ok && (Instr == INSTR_HALT);
  assign is_jmp   = dec_ok && (opcode == OP_JMP) && !is_halt;
  assign is_brf   = dec_ok && (opcode == OP_BRF);
  assign take     = is_jmp || (is_brf && flag_q);
  assign redirect = (state_q == RUN) && (state_d == REDIRECT);

  always_ff @(posedge CLK or negedge Init_n) begin
    if (!Init_n) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (Start) state_d = RUN;
      RUN: begin
        if (is_halt || Halt_in) state_d = DONE;
        else if (take)          state_d = REDIRECT;
      end
      REDIRECT: state_d = Halt_in ? DONE : RUN;
      DONE:     if (Start) state_d = RUN;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    Branch_en = 1'b0;
    FLAG_OUT  = 1'b0;
    Squash    = 1'b0;
    Done      = 1'b0;
    case (state_q)
      REDIRECT: begin
        Branch_en = 1'b1;
        FLAG_OUT  = 1'b1;
        Squash    = 1'b1;
      end
      DONE: begin
        Squash = 1'b1;
        Done   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge Init_n) begin
    if (!Init_n) begin
      flag_q   <= 1'b0;
      cnt_q    <= '0;
      target_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (Start) begin
            flag_q <= 1'b0;
            cnt_q  <= '0;
          end
        end
        RUN: begin
          if (Cmp_en) flag_q <= (Cmp_a == Cmp_b);
          if (redirect) begin
            target_q <= lut_rdata;
            if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign Target     = target_q;
  assign ProgState  = state_q;
  assign Branch_cnt = cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: reset, jumps, flag timing, squash, halt, saturation, async reset.
module tb_branch_ctrl;

  logic        CLK = 1'b0;
  logic        Init_n;
  logic        Start;
  logic [8:0]  Instr;
  logic        Instr_valid;
  logic        Cmp_en;
  logic [7:0]  Cmp_a, Cmp_b;
  logic        Halt_in;
  logic        Lut_we;
  logic [2:0]  Lut_waddr;
  logic [9:0]  Lut_wdata;
  logic        Branch_en, FLAG_OUT, Squash, Done;
  logic [9:0]  Target;
  logic [1:0]  ProgState;
  logic [15:0] Branch_cnt;

  int checks = 0;
  int errors = 0;

  branch_ctrl dut (
    .CLK(CLK), .Init_n(Init_n), .Start(Start), .Instr(Instr), .Instr_valid(Instr_valid),
    .Cmp_en(Cmp_en), .Cmp_a(Cmp_a), .Cmp_b(Cmp_b), .Halt_in(Halt_in),
    .Lut_we(Lut_we), .Lut_waddr(Lut_waddr), .Lut_wdata(Lut_wdata),
    .Branch_en(Branch_en), .FLAG_OUT(FLAG_OUT), .Target(Target), .ProgState(ProgState),
    .Squash(Squash), .Done(Done), .Branch_cnt(Branch_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    Init_n = 1'b0; Start = 1'b0; Instr = 9'h000; Instr_valid = 1'b1; Cmp_en = 1'b0;
    Cmp_a = 8'h00; Cmp_b = 8'h00; Halt_in = 1'b0; Lut_we = 1'b0; Lut_waddr = 3'd0; Lut_wdata = 10'h000;
    cyc(); cyc();
    checks++; if (ProgState !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", ProgState); end
    checks++; if ({Branch_en, FLAG_OUT, Squash, Done} !== 4'b0000)
      begin errors++; $display("FAIL reset_outs got %b exp 0000", {Branch_en, FLAG_OUT, Squash, Done}); end
    checks++; if (Target !== 10'h000 || Branch_cnt !== 16'h0000)
      begin errors++; $display("FAIL reset_regs target %h cnt %h exp 0 0", Target, Branch_cnt); end
    Init_n = 1'b1;
    cyc();
    checks++; if (ProgState !== 2'd0) begin errors++; $display("FAIL idle_hold got %0d exp 0", ProgState); end
    Start = 1'b1;
    cyc();
    Start = 1'b0;
    checks++; if (ProgState !== 2'd1 || Branch_cnt !== 16'h0000)
      begin errors++; $display("FAIL start state %0d cnt %h exp 1 0", ProgState, Branch_cnt); end
  endtask

  task automatic test_jump();
    Lut_we = 1'b1; Lut_waddr = 3'd3; Lut_wdata = 10'h05A;
    cyc();
    Lut_waddr = 3'd1; Lut_wdata = 10'h123;
    cyc();
    Lut_we = 1'b0;
    Instr = 9'h1E3;
    cyc();
    Instr = 9'h000;
    checks++; if (ProgState !== 2'd2 || {Branch_en, FLAG_OUT, Squash} !== 3'b111 || Target !== 10'h05A)
      begin errors++; $display("FAIL jmp_redirect state %0d be/fl/sq %b target %h exp 2 111 05a",
                               ProgState, {Branch_en, FLAG_OUT, Squash}, Target); end
    cyc();
    checks++; if (ProgState !== 2'd1 || Branch_cnt !== 16'd1 || {Branch_en, FLAG_OUT, Squash} !== 3'b000)
      begin errors++; $display("FAIL jmp_return state %0d cnt %0d outs %b exp 1 1 000",
                               ProgState, Branch_cnt, {Branch_en, FLAG_OUT, Squash}); end
    // Table write and read of the same index in one cycle: redirect uses the old entry.
    Lut_we = 1'b1; Lut_waddr = 3'd5; Lut_wdata = 10'h3FF; Instr = 9'h1E5;
    cyc();
    Lut_we = 1'b0; Instr = 9'h000;
    checks++; if (ProgState !== 2'd2 || Target !== 10'h000)
      begin errors++; $display("FAIL lut_same_cycle state %0d target %h exp 2 000", ProgState, Target); end
    cyc();
    Instr = 9'h1E5;
    cyc();
    Instr = 9'h000;
    checks++; if (Target !== 10'h3FF || Branch_cnt !== 16'd3)
      begin errors++; $display("FAIL lut_new target %h cnt %0d exp 3ff 3", Target, Branch_cnt); end
    cyc();
  endtask

  task automatic test_cond();
    Cmp_en = 1'b1; Cmp_a = 8'h42; Cmp_b = 8'h42; Instr = 9'h1C1;
    cyc();
    Cmp_en = 1'b0;
    checks++; if (ProgState !== 2'd1) begin errors++; $display("FAIL brf_old_flag state %0d exp 1", ProgState); end
    cyc();
    Instr = 9'h000;
    checks++; if (ProgState !== 2'd2 || Target !== 10'h123)
      begin errors++; $display("FAIL brf_taken state %0d target %h exp 2 123", ProgState, Target); end
    cyc();
    checks++; if (ProgState !== 2'd1 || Branch_cnt !== 16'd4)
      begin errors++; $display("FAIL brf_return state %0d cnt %0d exp 1 4", ProgState, Branch_cnt); end
    Instr = 9'h1E3; Instr_valid = 1'b0;
    cyc();
    Instr_valid = 1'b1;
    checks++; if (ProgState !== 2'd1) begin errors++; $display("FAIL invalid_instr state %0d exp 1", ProgState); end
    Instr = 9'h000; Cmp_en = 1'b1; Cmp_a = 8'h01; Cmp_b = 8'h02;
    cyc();
    Cmp_en = 1'b0; Instr = 9'h1C1;
    cyc();
    Instr = 9'h000;
    checks++; if (ProgState !== 2'd1 || Branch_cnt !== 16'd4)
      begin errors++; $display("FAIL brf_cleared state %0d cnt %0d exp 1 4", ProgState, Branch_cnt); end
  endtask

  task automatic test_squash();
    Cmp_en = 1'b1; Cmp_a = 8'h33; Cmp_b = 8'h33;
    cyc();
    Cmp_en = 1'b0; Instr = 9'h1E3;
    cyc();
    // REDIRECT cycle: this JMP and compare must both be ignored.
    Instr = 9'h1E1; Cmp_en = 1'b1; Cmp_a = 8'h01; Cmp_b = 8'h02;
    cyc();
    Instr = 9'h000; Cmp_en = 1'b0;
    checks++; if (ProgState !== 2'd1 || Branch_cnt !== 16'd5 || Target !== 10'h05A)
      begin errors++; $display("FAIL squash state %0d cnt %0d target %h exp 1 5 05a", ProgState, Branch_cnt, Target); end
    Instr = 9'h1C1;
    cyc();
    Instr = 9'h000;
    checks++; if (ProgState !== 2'd2 || Target !== 10'h123)
      begin errors++; $display("FAIL squash_flag state %0d target %h exp 2 123", ProgState, Target); end
    cyc();
  endtask

  task automatic test_halt();
    Instr = 9'h1FF;
    cyc();
    Instr = 9'h1E3;
    checks++; if (ProgState !== 2'd3 || {Done, Squash, Branch_en} !== 3'b110)
      begin errors++; $display("FAIL halt state %0d done/sq/be %b exp 3 110", ProgState, {Done, Squash, Branch_en}); end
    cyc();
    Instr = 9'h000;
    checks++; if (ProgState !== 2'd3 || Branch_cnt !== 16'd6)
      begin errors++; $display("FAIL done_frozen state %0d cnt %0d exp 3 6", ProgState, Branch_cnt); end
    Start = 1'b1;
    cyc();
    Start = 1'b0;
    checks++; if (ProgState !== 2'd1 || Branch_cnt !== 16'd0 || Done !== 1'b0)
      begin errors++; $display("FAIL restart state %0d cnt %0d done %b exp 1 0 0", ProgState, Branch_cnt, Done); end
    Instr = 9'h1C1;
    cyc();
    checks++; if (ProgState !== 2'd1) begin errors++; $display("FAIL restart_flag state %0d exp 1", ProgState); end
    Instr = 9'h1E3;
    cyc();
    Instr = 9'h000; Halt_in = 1'b1;
    cyc();
    Halt_in = 1'b0;
    checks++; if (ProgState !== 2'd3 || Branch_cnt !== 16'd1)
      begin errors++; $display("FAIL halt_in_redirect state %0d cnt %0d exp 3 1", ProgState, Branch_cnt); end
    Start = 1'b1;
    cyc();
    Start = 1'b0;
  endtask

  task automatic test_saturation();
    // Preload the counter near saturation instead of spending 128k cycles on real jumps.
    force dut.cnt_q = 16'hFFFE;
    #1;
    release dut.cnt_q;
    for (int i = 0; i < 3; i++) begin
      Instr = 9'h1E3;
      cyc();
      Instr = 9'h000;
      cyc();
    end
    checks++; if (Branch_cnt !== 16'hFFFF)
      begin errors++; $display("FAIL saturate cnt %h exp ffff", Branch_cnt); end
  endtask

  task automatic test_async_reset();
    Instr = 9'h1E3;
    cyc();
    Instr = 9'h000;
    checks++; if (Branch_en !== 1'b1) begin errors++; $display("FAIL pre_reset be %b exp 1", Branch_en); end
    #2;
    Init_n = 1'b0;
    #1;
    checks++; if ({Branch_en, FLAG_OUT, Squash} !== 3'b000 || ProgState !== 2'd0 || Target !== 10'h000)
      begin errors++; $display("FAIL async_reset outs %b state %0d target %h exp 000 0 000",
                               {Branch_en, FLAG_OUT, Squash}, ProgState, Target); end
    cyc();
    Init_n = 1'b1;
    cyc();
  endtask

  initial begin
    test_reset();
    test_jump();
    test_cond();
    test_squash();
    test_halt();
    test_saturation();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
